rom_sram_sequencer: RTL and testbench
=====================================

Name: rom_sram_sequencer

Overview:
Single owner of the external async-SRAM ROM store and its chip-select/write-enable/address/data lines. During boot it accepts the ROM byte stream from the data loader and turns each byte into a timed SRAM write (setup, pulse, hold). After the loader signals completion it arbitrates round-robin between two read requesters (main CPU and sound CPU) and returns each byte after a fixed access wait. It sits between the loader/CPU fabric and the SRAM storage wrapper.

Parameters:
WR_CYCLES, 3, width of the write-enable pulse in clk cycles (min 1)
RD_CYCLES, 2, SRAM access wait in clk cycles before read data is captured (min 1)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader byte valid
ld_ready  out  1  sequencer accepts a loader byte this cycle
ld_addr  in  17  loader byte address {bank[1:0], addr[14:0]}
ld_data  in  8  loader byte
ld_done  in  1  one-cycle pulse: loading finished
loaded  out  1  load phase complete; read service enabled
rq0_req  in  1  requester 0 read request, level, held until ack
rq0_addr  in  17  requester 0 address
rq0_ack  out  1  one-cycle pulse: rq0_data valid
rq0_data  out  8  requester 0 read data, held until next rq0 ack
rq1_req, rq1_addr, rq1_ack, rq1_data: same as requester 0
mem_cs  out  1  storage select
mem_wr_en  out  1  storage write enable
mem_addr  out  17  storage address
mem_din  out  8  storage write data
mem_dout  in  8  storage read data

Behaviour:
- Reset (async, reset_n=0): state IDLE; every output 0 (ld_ready, loaded, acks, data regs, mem_*); rr pointer = requester 0. Reset mid-write drops mem_wr_en/mem_cs immediately; no completion of the write.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_DONE.
- ld_ready = 1 only in IDLE with loaded=0. Transfer on ld_valid & ld_ready: latch addr/data, go WR_SETUP.
- WR_SETUP: 1 cycle, mem_cs=1, mem_wr_en=0, addr/din driven. WR_PULSE: WR_CYCLES cycles, mem_wr_en=1. WR_HOLD: 1 cycle, mem_wr_en=0, mem_cs=1, addr/din unchanged. Then IDLE (mem_cs=0). Byte throughput: one per WR_CYCLES+3 cycles.
- ld_done: sets a done-pending flag; loaded becomes 1 on the first cycle the FSM is in IDLE with the flag set (a write in flight completes first). ld_done after loaded=1 is ignored. ld_valid after loaded=1 is ignored (ld_ready stays 0).
- Reads: serviced only when loaded=1; before that requests wait (no ack, no error).
- Arbitration in IDLE: if one req is high, grant it; if both, grant the one not last granted (rr pointer); pointer updates on grant. Latch granted address, go RD_WAIT.
- RD_WAIT: RD_CYCLES cycles, mem_cs=1, mem_wr_en=0, mem_addr=latched addr. On last RD_WAIT cycle's edge capture mem_dout into the granted port's data reg, go RD_DONE.
- RD_DONE: 1 cycle, mem_cs=0, granted ack=1. Then IDLE.
- Latency: req seen high in IDLE at cycle 0 -> ack high at cycle RD_CYCLES+1; new request sampled earliest at cycle RD_CYCLES+2. Requester must drop req in the cycle after ack; a req still high in IDLE is a new request.
- mem_addr/mem_din hold their last values when mem_cs=0 (no spurious toggling); mem_wr_en never 1 while mem_cs=0.
- Address is 17 bits end to end; no wrap or bank remapping applied.

Test Plan:
- Reset then 4 loader bytes (addr 0x00000..0x00003, data 0xA0..0xA3, ld_valid held) -> each accepted 6 cycles apart (defaults), mem_wr_en high exactly 3 cycles per byte, bracketed by 1 cycle of cs-only setup/hold; ld_ready 0 during writes.
- ld_done pulsed during 2nd WR_PULSE cycle -> write completes, loaded=1 on following IDLE cycle; subsequent ld_valid never accepted.
- loaded=1, rq0_req addr 0x18002 with SRAM model returning 0x5C -> mem_addr=0x18002 with cs high 2 cycles, rq0_ack at cycle 3, rq0_data=0x5C held after ack.
- rq0 and rq1 held high continuously for 6 requests -> grants alternate 0,1,0,1,0,1; each ack only on its own port.
- rq1_req raised before loaded -> no ack, mem_cs stays 0 until loaded=1, then served with normal latency.
- reset_n asserted in WR_PULSE -> mem_wr_en and mem_cs 0 same cycle (async), all outputs 0, loaded=0, ld_ready=1 first cycle after release.

Source files
------------

// File: rtl/rom_sram_sequencer.sv
// rom_sram_sequencer: sole owner of the async-SRAM ROM store.
// Boot phase: each loader byte becomes a setup / write-pulse / hold sequence.
// Run phase: round-robin read service for two requesters with a fixed access wait.
module rom_sram_sequencer #(
  parameter int WR_CYCLES = 3,
  parameter int RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [16:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        ld_done,
  output logic        loaded,
  input  logic        rq0_req,
  input  logic [16:0] rq0_addr,
  output logic        rq0_ack,
  output logic [7:0]  rq0_data,
  input  logic        rq1_req,
  input  logic [16:0] rq1_addr,
  output logic        rq1_ack,
  output logic [7:0]  rq1_data,
  output logic        mem_cs,
  output logic        mem_wr_en,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_SETUP = 3'd1;
  localparam logic [2:0] S_WR_PULSE = 3'd2;
  localparam logic [2:0] S_WR_HOLD  = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_RD_DONE  = 3'd5;

  localparam int MAXC  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_loaded;
  logic             r_grant;
  logic             r_prio;
  logic             r_ld_ready;
  logic             r_mem_cs;
  logic             r_mem_wr_en;
  logic [16:0]      r_mem_addr;
  logic [7:0]       r_mem_din;
  logic             r_rq0_ack;
  logic             r_rq1_ack;
  logic [7:0]       r_rq0_data;
  logic [7:0]       r_rq1_data;

  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_grant_vld;
  logic             w_grant_sel;
  logic             w_pending_next;
  logic             w_loaded_next;
  logic             w_capture;

  // Done flag is only meaningful until the load phase closes.
  assign w_pending_next = (r_pending | ld_done) & ~r_loaded;
  // Loaded rises on entry to IDLE so the first IDLE cycle already blocks the loader.
  assign w_loaded_next  = r_loaded | ((w_next_state == S_IDLE) & w_pending_next);
  assign w_capture      = (r_state == S_RD_WAIT) && (r_cnt == RD_LAST);

  // Next-state, loader accept and read arbitration.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_grant_vld  = 1'b0;
    w_grant_sel  = r_grant;
    case (r_state)
      S_IDLE: begin
        if (!r_loaded) begin
          if (ld_valid && r_ld_ready) begin
            w_accept     = 1'b1;
            w_next_state = S_WR_SETUP;
          end
        end else if (rq0_req || rq1_req) begin
          w_grant_vld  = 1'b1;
          w_grant_sel  = (rq0_req && rq1_req) ? r_prio : rq1_req;
          w_next_state = S_RD_WAIT;
          w_cnt_next   = '0;
        end
      end
      S_WR_SETUP: begin
        w_next_state = S_WR_PULSE;
        w_cnt_next   = '0;
      end
      S_WR_PULSE: begin
        if (r_cnt == WR_LAST) w_next_state = S_WR_HOLD;
        else                  w_cnt_next   = r_cnt + 1'b1;
      end
      S_WR_HOLD: w_next_state = S_IDLE;
      S_RD_WAIT: begin
        if (r_cnt == RD_LAST) w_next_state = S_RD_DONE;
        else                  w_cnt_next   = r_cnt + 1'b1;
      end
      S_RD_DONE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Control state: FSM, counter, done flag, arbitration pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_loaded  <= 1'b0;
      r_grant   <= 1'b0;
      r_prio    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_pending <= w_pending_next;
      r_loaded  <= w_loaded_next;
      if (w_grant_vld) begin
        r_grant <= w_grant_sel;
        r_prio  <= ~w_grant_sel;
      end
    end
  end

  // Registered outputs derived from the next state; addr/din only move on a new transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_ready  <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_rq0_ack   <= 1'b0;
      r_rq1_ack   <= 1'b0;
      r_rq0_data  <= '0;
      r_rq1_data  <= '0;
    end else begin
      r_ld_ready  <= (w_next_state == S_IDLE) && !w_loaded_next;
      r_mem_cs    <= (w_next_state == S_WR_SETUP) || (w_next_state == S_WR_PULSE) ||
                     (w_next_state == S_WR_HOLD)  || (w_next_state == S_RD_WAIT);
      r_mem_wr_en <= (w_next_state == S_WR_PULSE);
      if (w_accept) begin
        r_mem_addr <= ld_addr;
        r_mem_din  <= ld_data;
      end else if (w_grant_vld) begin
        r_mem_addr <= w_grant_sel ? rq1_addr : rq0_addr;
      end
      r_rq0_ack <= (w_next_state == S_RD_DONE) && !r_grant;
      r_rq1_ack <= (w_next_state == S_RD_DONE) &&  r_grant;
      if (w_capture && !r_grant) r_rq0_data <= mem_dout;
      if (w_capture &&  r_grant) r_rq1_data <= mem_dout;
    end
  end

  assign ld_ready  = r_ld_ready;
  assign loaded    = r_loaded;
  assign rq0_ack   = r_rq0_ack;
  assign rq1_ack   = r_rq1_ack;
  assign rq0_data  = r_rq0_data;
  assign rq1_data  = r_rq1_data;
  assign mem_cs    = r_mem_cs;
  assign mem_wr_en = r_mem_wr_en;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_rom_sram_sequencer.sv
// Directed bench for rom_sram_sequencer with a behavioural async-SRAM model.
module tb_rom_sram_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid, ld_ready, ld_done, loaded;
  logic [16:0] ld_addr;
  logic [7:0]  ld_data;
  logic        rq0_req, rq0_ack, rq1_req, rq1_ack;
  logic [16:0] rq0_addr, rq1_addr;
  logic [7:0]  rq0_data, rq1_data;
  logic        mem_cs, mem_wr_en;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  sram [0:131071];

  int n_checks = 0;
  int n_fail   = 0;

  rom_sram_sequencer #(.WR_CYCLES(3), .RD_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .loaded(loaded),
    .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_ack(rq0_ack), .rq0_data(rq0_data),
    .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_ack(rq1_ack), .rq1_data(rq1_data),
    .mem_cs(mem_cs), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write on strobe, combinational read.
  always @(posedge clk) if (mem_cs && mem_wr_en) sram[mem_addr] <= mem_din;
  assign mem_dout = sram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ld_ready"}, {31'd0, ld_ready}, 0);
    check_eq({tag, "_loaded"},   {31'd0, loaded}, 0);
    check_eq({tag, "_acks"},     {30'd0, rq1_ack, rq0_ack}, 0);
    check_eq({tag, "_data"},     {16'd0, rq1_data, rq0_data}, 0);
    check_eq({tag, "_cs_we"},    {30'd0, mem_cs, mem_wr_en}, 0);
    check_eq({tag, "_addr"},     {15'd0, mem_addr}, 0);
    check_eq({tag, "_din"},      {24'd0, mem_din}, 0);
  endtask

  // One isolated read: caller is at a negedge with the DUT idle and loaded.
  task automatic do_read(input bit sel, input logic [16:0] a, input logic [7:0] exp);
    if (sel) begin rq1_req = 1'b1; rq1_addr = a; end
    else     begin rq0_req = 1'b1; rq0_addr = a; end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        check_eq("rd_cs", {31'd0, mem_cs}, 1);
        check_eq("rd_we", {31'd0, mem_wr_en}, 0);
        check_eq("rd_addr", {15'd0, mem_addr}, {15'd0, a});
        check_eq("rd_noack", {30'd0, rq1_ack, rq0_ack}, 0);
      end else if (k == 3) begin
        check_eq("rd_ack", {30'd0, rq1_ack, rq0_ack}, sel ? 2 : 1);
        check_eq("rd_cs_off", {31'd0, mem_cs}, 0);
        check_eq("rd_data", {24'd0, sel ? rq1_data : rq0_data}, {24'd0, exp});
        rq0_req = 1'b0;
        rq1_req = 1'b0;
      end else begin
        check_eq("rd_ack_drop", {30'd0, rq1_ack, rq0_ack}, 0);
        check_eq("rd_data_hold", {24'd0, sel ? rq1_data : rq0_data}, {24'd0, exp});
      end
    end
  endtask

  initial begin
    logic exp_cs, exp_we, exp_rdy, exp_ld;
    int   b, p;
    sram[17'h18002] = 8'h5C;
    reset_n = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    rq0_req = 1'b0; rq0_addr = '0; rq1_req = 1'b0; rq1_addr = '0;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    ld_valid = 1'b1; ld_addr = 17'h0; ld_data = 8'hA0;

    // Load four bytes back-to-back, ld_done during the 4th byte's 2nd pulse cycle.
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      b = c / 6;
      p = c % 6;
      if (c < 24) begin
        exp_cs  = (p != 0);
        exp_we  = (p >= 2 && p <= 4);
        exp_rdy = (p == 0);
        exp_ld  = 1'b0;
      end else begin
        exp_cs = 1'b0; exp_we = 1'b0; exp_rdy = 1'b0; exp_ld = 1'b1;
      end
      check_eq("ld_cs", {31'd0, mem_cs}, {31'd0, exp_cs});
      check_eq("ld_we", {31'd0, mem_wr_en}, {31'd0, exp_we});
      check_eq("ld_ready", {31'd0, ld_ready}, {31'd0, exp_rdy});
      check_eq("ld_loaded", {31'd0, loaded}, {31'd0, exp_ld});
      if (c < 24 && p != 0) begin
        check_eq("ld_addr", {15'd0, mem_addr}, b);
        check_eq("ld_din", {24'd0, mem_din}, 32'hA0 + b);
      end else if (c >= 6) begin
        check_eq("ld_addr_hold", {15'd0, mem_addr}, (c >= 24) ? 3 : b - 1);
      end
      ld_addr = 17'(b);
      ld_data = 8'(8'hA0 + b);
      ld_done = (c == 21);
    end

    // Reads after load; ld_valid stays high and must stay ignored.
    do_read(1'b0, 17'h18002, 8'h5C);
    do_read(1'b1, 17'h00003, 8'hA3);
    check_eq("ld_ignored", {31'd0, ld_ready}, 0);

    // Both requesters held: grants alternate starting with requester 0.
    rq0_req = 1'b1; rq0_addr = 17'h00001;
    rq1_req = 1'b1; rq1_addr = 17'h00002;
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      p = (t - 1) % 4;
      b = ((t - 1) / 4) % 2;
      if (p <= 1) begin
        check_eq("rr_cs", {31'd0, mem_cs}, 1);
        check_eq("rr_addr", {15'd0, mem_addr}, (b == 1) ? 2 : 1);
      end else if (p == 2) begin
        check_eq("rr_ack", {30'd0, rq1_ack, rq0_ack}, (b == 1) ? 2 : 1);
        check_eq("rr_data", {24'd0, (b == 1) ? rq1_data : rq0_data}, (b == 1) ? 32'hA2 : 32'hA1);
        if (t == 23) begin rq0_req = 1'b0; rq1_req = 1'b0; end
      end else begin
        check_eq("rr_idle", {29'd0, mem_cs, rq1_ack, rq0_ack}, 0);
      end
    end

    // Fresh reset, start a write, then reset in the middle of the pulse.
    ld_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ld_valid = 1'b1; ld_addr = 17'h00010; ld_data = 8'h77;
    @(negedge clk);
    check_eq("rst2_ready", {31'd0, ld_ready}, 1);
    @(negedge clk);
    check_eq("wr2_setup", {30'd0, mem_cs, mem_wr_en}, 2);
    @(negedge clk);
    check_eq("wr2_pulse", {30'd0, mem_cs, mem_wr_en}, 3);
    check_eq("wr2_addr", {15'd0, mem_addr}, 32'h10);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    ld_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", {31'd0, ld_ready}, 1);
    check_eq("rel_loaded", {31'd0, loaded}, 0);
    check_eq("rel_cs", {31'd0, mem_cs}, 0);

    // Request before loaded waits, then is served once loaded rises.
    rq1_req = 1'b1; rq1_addr = 17'h00002;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("pre_wait", {30'd0, mem_cs, rq1_ack}, 0);
    end
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    check_eq("pre_loaded", {31'd0, loaded}, 1);
    check_eq("pre_ready", {31'd0, ld_ready}, 0);
    @(negedge clk);
    check_eq("pre_cs1", {31'd0, mem_cs}, 1);
    check_eq("pre_addr", {15'd0, mem_addr}, 2);
    @(negedge clk);
    check_eq("pre_cs2", {30'd0, mem_cs, rq1_ack}, 2);
    @(negedge clk);
    check_eq("pre_ack", {30'd0, rq1_ack, rq0_ack}, 2);
    check_eq("pre_data", {24'd0, rq1_data}, 32'hA2);
    rq1_req = 1'b0;
    @(negedge clk);
    check_eq("pre_ack_drop", {30'd0, rq1_ack, mem_cs}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
